// File: rtl/dynamic_pkg.sv
// Shared constants and types for the 7-segment receive-side capture.
// Anode codes are active-low one-hot, digit0 in the LSB position.
package dynamic_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_IDLE = 4'b1111;

    // COLk means digit k is the next one expected
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } state_e;

endpackage

// File: rtl/dynamic_capture_an_decode.sv
// Anode-select decoder: an -> digit index, legal, idle.
// Purely combinational; reusable by other display monitors.
module an_decode
    import dynamic_pkg::*;
(
    input  logic [3:0] an,
    output logic [1:0] idx,
    output logic       legal,
    output logic       idle
);

    // Map the four one-hot-low codes to an index; flag idle/illegal
    always_comb begin
        idx   = 2'd0;
        legal = 1'b0;
        idle  = 1'b0;
        unique case (an)
            AN_D0:   begin idx = 2'd0; legal = 1'b1; end
            AN_D1:   begin idx = 2'd1; legal = 1'b1; end
            AN_D2:   begin idx = 2'd2; legal = 1'b1; end
            AN_D3:   begin idx = 2'd3; legal = 1'b1; end
            AN_IDLE: idle = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/dynamic_capture.sv
// Reassembles multiplexed BCD digits into a 16-bit value, published
// after STABLE_FRAMES identical frames. Optional macro: BCD_CHECK_EN.
module dynamic_capture
    import dynamic_pkg::*;
#(
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk_e,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [3:0]  bcd,
    output logic [15:0] num,
    output logic        num_valid,
    output logic        update,
    output logic        frame_err
);

    localparam int          FW = NUM_DIGITS * 4;
    localparam logic [3:0]  SF = 4'(STABLE_FRAMES);

    logic [1:0]    idx;
    logic          legal;
    logic          idle;
    logic          bcd_bad;
    logic [FW-1:0] frame;
    logic [3:0]    stable_n;

    state_e        state_q, state_d;
    logic [11:0]   part_q, part_d;
    logic [FW-1:0] prev_q, prev_d;
    logic [3:0]    stable_q, stable_d;
    logic [FW-1:0] num_q, num_d;
    logic          num_valid_q, num_valid_d;
    logic          update_q, update_d;
    logic          frame_err_q, frame_err_d;

    an_decode u_an_decode (
        .an    (an),
        .idx   (idx),
        .legal (legal),
        .idle  (idle)
    );

`ifdef BCD_CHECK_EN
    assign bcd_bad = legal && (bcd > 4'd9);
`else
    assign bcd_bad = 1'b0;
`endif

    // Digit3 arrives live; digits 0..2 come from the partial register
    assign frame = {bcd, part_q};

    // Stable count a completed frame would produce
    always_comb begin
        stable_n = 4'd1;
        if (frame == prev_q) begin
            stable_n = (stable_q >= SF) ? SF : stable_q + 4'd1;
        end
    end

    // Frame FSM, stable history and publish decision
    always_comb begin
        state_d     = state_q;
        part_d      = part_q;
        prev_d      = prev_q;
        stable_d    = stable_q;
        num_d       = num_q;
        num_valid_d = num_valid_q;
        update_d    = 1'b0;
        frame_err_d = 1'b0;
        if (!legal && !idle) begin
            frame_err_d = 1'b1;
            part_d      = '0;
            state_d     = SYNC;
        end else if (bcd_bad) begin
            frame_err_d = 1'b1;
            part_d      = '0;
            state_d     = SYNC;
        end else if (legal) begin
            if (state_q == SYNC) begin
                if (idx == 2'd0) begin
                    part_d  = {8'd0, bcd};
                    state_d = COL1;
                end
            end else if (idx == 2'(state_q)) begin
                unique case (idx)
                    2'd1: begin
                        part_d[7:4] = bcd;
                        state_d     = COL2;
                    end
                    2'd2: begin
                        part_d[11:8] = bcd;
                        state_d      = COL3;
                    end
                    default: begin
                        state_d  = SYNC;
                        prev_d   = frame;
                        stable_d = stable_n;
                        if (stable_n == SF &&
                            (!num_valid_q || frame != num_q)) begin
                            num_d       = frame;
                            num_valid_d = 1'b1;
                            update_d    = 1'b1;
                        end
                    end
                endcase
            end else if (idx == 2'd0) begin
                frame_err_d = 1'b1;
                part_d      = {8'd0, bcd};
                state_d     = COL1;
            end else begin
                frame_err_d = 1'b1;
                part_d      = '0;
                state_d     = SYNC;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_e) begin
        if (rst) begin
            state_q     <= SYNC;
            part_q      <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            num_q       <= '0;
            num_valid_q <= 1'b0;
            update_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            part_q      <= part_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
            update_q    <= update_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign num       = num_q;
    assign num_valid = num_valid_q;
    assign update    = update_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_dynamic_capture.sv
// Directed self-checking bench for dynamic_capture (STABLE_FRAMES=2).
// Expectations for the hex-digit case follow BCD_CHECK_EN.
module tb_dynamic_capture;

    logic        clk_e;
    logic        rst;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic [15:0] num;
    logic        num_valid;
    logic        update;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int upd_cnt  = 0;

    dynamic_capture #(.STABLE_FRAMES(2)) dut (
        .clk_e     (clk_e),
        .rst       (rst),
        .an        (an),
        .bcd       (bcd),
        .num       (num),
        .num_valid (num_valid),
        .update    (update),
        .frame_err (frame_err)
    );

    initial begin
        clk_e = 1'b0;
        forever #5 clk_e = ~clk_e;
    end

    function automatic logic [3:0] code(input int k);
        logic [3:0] c;
        case (k)
            0: c = 4'b1110;
            1: c = 4'b1101;
            2: c = 4'b1011;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk_e);
        an  = a;
        bcd = b;
        @(posedge clk_e);
        #1;
        if (frame_err) err_cnt++;
        if (update) upd_cnt++;
    endtask

    task automatic dig(input int k, input logic [3:0] b);
        step(code(k), b);
    endtask

    task automatic send(input logic [15:0] v, input int gap);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (gap) step(4'b1111, 4'h0);
            dig(k, v[4*k +: 4]);
        end
    endtask

    task automatic clr();
        err_cnt = 0;
        upd_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'b1111;
        bcd = 4'h0;
        step(4'b1111, 4'h0);
        step(4'b1111, 4'h0);
        chk("rst_num", 32'(num), 32'h0);
        chk("rst_valid", 32'(num_valid), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        rst = 1'b0;

        // 1: two identical frames publish once
        clr();
        send(16'h1234, 0);
        chk("f1_update", 32'(update), 32'h0);
        chk("f1_valid", 32'(num_valid), 32'h0);
        send(16'h1234, 0);
        chk("f2_update", 32'(update), 32'h1);
        chk("f2_num", 32'(num), 32'h1234);
        chk("f2_valid", 32'(num_valid), 32'h1);
        step(4'b1111, 4'h0);
        chk("f2_pulse", 32'(update), 32'h0);

        // 2: repeats do not re-publish; new value needs two frames
        clr();
        repeat (3) send(16'h1234, 0);
        chk("rep_upd", 32'(upd_cnt), 32'h0);
        chk("rep_num", 32'(num), 32'h1234);
        send(16'h5678, 0);
        chk("n1_update", 32'(update), 32'h0);
        chk("n1_num", 32'(num), 32'h1234);
        send(16'h5678, 0);
        chk("n2_update", 32'(update), 32'h1);
        chk("n2_num", 32'(num), 32'h5678);
        chk("n2_cnt", 32'(upd_cnt), 32'h1);
        chk("n2_err", 32'(err_cnt), 32'h0);

        // 3: idle gaps between digits
        clr();
        send(16'h1234, 3);
        send(16'h1234, 3);
        chk("gap_num", 32'(num), 32'h1234);
        chk("gap_upd", 32'(upd_cnt), 32'h1);
        chk("gap_err", 32'(err_cnt), 32'h0);

        // 4a: digit0 then digit2
        clr();
        dig(0, 4'h1);
        dig(2, 4'h3);
        chk("ooo_err", 32'(frame_err), 32'h1);
        chk("ooo_upd", 32'(update), 32'h0);
        step(4'b1111, 4'h0);
        chk("ooo_pulse", 32'(frame_err), 32'h0);

        // 4b: digit0 restart resyncs immediately
        clr();
        dig(0, 4'h1);
        dig(1, 4'h2);
        dig(0, 4'h1);
        chk("rs_err", 32'(frame_err), 32'h1);
        dig(1, 4'h2);
        dig(2, 4'h3);
        dig(3, 4'h4);
        chk("rs_err_cnt", 32'(err_cnt), 32'h1);
        chk("rs_first", 32'(update), 32'h0);
        send(16'h4321, 0);
        chk("rs_update", 32'(update), 32'h1);
        chk("rs_num", 32'(num), 32'h4321);

        // 4c: illegal anode code, then a lone digit1 is ignored
        clr();
        step(4'b1100, 4'h0);
        chk("ill_err", 32'(frame_err), 32'h1);
        dig(1, 4'h5);
        chk("sync_ign", 32'(frame_err), 32'h0);

        // 5: reset mid-frame discards partial frame and history
        clr();
        dig(0, 4'h6);
        dig(1, 4'h7);
        rst = 1'b1;
        step(4'b1111, 4'h0);
        rst = 1'b0;
        chk("mid_num", 32'(num), 32'h0);
        chk("mid_valid", 32'(num_valid), 32'h0);
        dig(2, 4'h8);
        dig(3, 4'h9);
        chk("mid_tail", 32'(update), 32'h0);
        send(16'h9876, 0);
        chk("mid_f1", 32'(num_valid), 32'h0);
        send(16'h9876, 0);
        chk("mid_num2", 32'(num), 32'h9876);
        chk("mid_upd", 32'(upd_cnt), 32'h1);
        chk("mid_err", 32'(err_cnt), 32'h0);

        // 6: non-decimal nibble in digit2
        clr();
        send(16'h1A34, 0);
        send(16'h1A34, 0);
`ifdef BCD_CHECK_EN
        chk("hex_err", 32'(err_cnt), 32'h2);
        chk("hex_num", 32'(num), 32'h9876);
        chk("hex_upd", 32'(upd_cnt), 32'h0);
`else
        chk("hex_err", 32'(err_cnt), 32'h0);
        chk("hex_num", 32'(num), 32'h1A34);
        chk("hex_upd", 32'(upd_cnt), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
